// File: rtl/floo_pkg.sv
// Shared types and default parameters for the FlooNoC memory port arbiter.
// Holds the arbiter FSM state encoding and default sizing constants.
package floo_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned NumReqDflt         = 2;
  localparam int unsigned AddrWidthDflt      = 48;
  localparam int unsigned DataWidthDflt      = 64;
  localparam int unsigned MaxOutstandingDflt = 8;

endpackage

// File: rtl/floo_arb_route_fifo.sv
// Route FIFO: remembers which requester owns each in-flight memory request.
// Depth must be a power of two so the pointers wrap naturally.
module floo_arb_route_fifo
  import floo_pkg::*;
#(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = MaxOutstandingDflt
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             push, pop;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/floo_mem_port_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among NumReq requesters.
// Optional stall counter enabled by defining FLOO_ARB_STALL_CNT_EN.
module floo_mem_port_arbiter
  import floo_pkg::*;
#(
  parameter int unsigned NumReq         = NumReqDflt,
  parameter int unsigned AddrWidth      = AddrWidthDflt,
  parameter int unsigned DataWidth      = DataWidthDflt,
  parameter int unsigned MaxOutstanding = MaxOutstandingDflt
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0]                   req_we_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
  output logic [NumReq-1:0]                   rsp_valid_o,
  input  logic [NumReq-1:0]                   rsp_ready_i,
  output logic [DataWidth-1:0]                rsp_rdata_o,
  output logic                                mem_req_valid_o,
  input  logic                                mem_req_ready_i,
  output logic [AddrWidth-1:0]                mem_req_addr_o,
  output logic                                mem_req_we_o,
  output logic [DataWidth-1:0]                mem_req_wdata_o,
  input  logic                                mem_rsp_valid_i,
  output logic                                mem_rsp_ready_o,
  input  logic [DataWidth-1:0]                mem_rsp_rdata_i,
  output logic [$clog2(MaxOutstanding):0]     outstanding_o,
  output logic [31:0]                         stall_cnt_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  arb_state_e      state_q;
  logic [IdxW-1:0] rr_q, gnt_q, sel, sel_nxt, head;
  logic            sel_vld, full, empty, hs, pop;

  // Lowest offset from rr_q wins, so scan downward and let it overwrite.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    sel     = rr_q;
    sel_vld = 1'b0;
    if (state_q == LOCKED) begin
      sel     = gnt_q;
      sel_vld = 1'b1;
    end else begin
      for (int i = NumReq - 1; i >= 0; i--) begin
        idx = (int'(rr_q) + i) % NumReq;
        if (req_valid_i[idx]) begin
          sel     = IdxW'(idx);
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign sel_nxt = (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;

  assign mem_req_valid_o = !rst_i && sel_vld && !full;
  assign mem_req_addr_o  = req_addr_i[sel];
  assign mem_req_we_o    = req_we_i[sel];
  assign mem_req_wdata_o = req_wdata_i[sel];
  assign hs              = mem_req_valid_o && mem_req_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (!rst_i && sel_vld) begin
      req_ready_o[sel] = mem_req_ready_i && !full;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
    end else if (hs) begin
      state_q <= IDLE;
      rr_q    <= sel_nxt;
    end else if (mem_req_valid_o) begin
      state_q <= LOCKED;
      gnt_q   <= sel;
    end
  end

  floo_arb_route_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) i_route_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  assign mem_rsp_ready_o = !rst_i && !empty && rsp_ready_i[head];
  assign rsp_rdata_o     = mem_rsp_rdata_i;
  assign pop             = mem_rsp_valid_i && mem_rsp_ready_o;

  always_comb begin
    rsp_valid_o = '0;
    if (!rst_i && !empty) begin
      rsp_valid_o[head] = mem_rsp_valid_i;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    !(empty && mem_rsp_valid_i));

`ifdef FLOO_ARB_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall_ev;

  assign stall_ev = (mem_req_valid_o && !mem_req_ready_i) ||
                    ((|req_valid_i) && full);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (stall_ev && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
